// File: rtl/tpu_wb_master.sv
// Wishbone classic host for the edu TPU slave window: streams weights and inputs
// to BASE_ADDRESS, then reads results back onto a valid/ready output stream.
module tpu_wb_master #(
  parameter logic [31:0] BASE_ADDRESS = 32'h3000_0000,
  parameter int unsigned N_WEIGHT     = 4,
  parameter int unsigned N_INPUT      = 6,
  parameter int unsigned N_RESULT     = 5,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        error,
  input  logic        s_valid,
  input  logic [31:0] s_data,
  output logic        s_ready,
  output logic        r_valid,
  output logic [31:0] r_data,
  input  logic        r_ready,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WRITE, S_READ, S_PUSH, S_DONE, S_ERR
  } state_t;

  localparam logic [7:0] LAST_W = 8'(N_WEIGHT + N_INPUT - 1);
  localparam logic [7:0] LAST_R = 8'(N_RESULT - 1);
  localparam logic [7:0] TMO    = 8'(TIMEOUT);

  state_t      state, state_d;
  logic [7:0]  wcnt, wcnt_d, rcnt, rcnt_d, tcnt, tcnt_d;
  logic        cyc_d, stb_d, we_d, s_ready_d, r_valid_d, done_d, error_d, busy_d;
  logic [31:0] dat_d, r_data_d;

  assign wb_adr_o = BASE_ADDRESS;
  assign wb_sel_o = 4'hF;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      wcnt     <= '0;
      rcnt     <= '0;
      tcnt     <= '0;
      wb_cyc_o <= 1'b0;
      wb_stb_o <= 1'b0;
      wb_we_o  <= 1'b0;
      wb_dat_o <= '0;
      s_ready  <= 1'b0;
      r_valid  <= 1'b0;
      r_data   <= '0;
      done     <= 1'b0;
      error    <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_d;
      wcnt     <= wcnt_d;
      rcnt     <= rcnt_d;
      tcnt     <= tcnt_d;
      wb_cyc_o <= cyc_d;
      wb_stb_o <= stb_d;
      wb_we_o  <= we_d;
      wb_dat_o <= dat_d;
      s_ready  <= s_ready_d;
      r_valid  <= r_valid_d;
      r_data   <= r_data_d;
      done     <= done_d;
      error    <= error_d;
      busy     <= busy_d;
    end
  end

  // Outputs are computed as next-state values so every port comes from a flop.
  always_comb begin
    state_d   = state;
    wcnt_d    = wcnt;
    rcnt_d    = rcnt;
    tcnt_d    = tcnt;
    cyc_d     = wb_cyc_o;
    stb_d     = wb_stb_o;
    we_d      = wb_we_o;
    dat_d     = wb_dat_o;
    s_ready_d = s_ready;
    r_valid_d = r_valid;
    r_data_d  = r_data;
    done_d    = 1'b0;
    error_d   = error;
    case (state)
      S_IDLE, S_ERR: begin
        if (start) begin
          state_d   = S_FETCH;
          wcnt_d    = '0;
          rcnt_d    = '0;
          tcnt_d    = '0;
          error_d   = 1'b0;
          s_ready_d = 1'b1;
        end
      end
      S_FETCH: begin
        if (s_valid && s_ready) begin
          dat_d     = s_data;
          s_ready_d = 1'b0;
          cyc_d     = 1'b1;
          stb_d     = 1'b1;
          we_d      = 1'b1;
          tcnt_d    = '0;
          state_d   = S_WRITE;
        end
      end
      S_WRITE, S_READ: begin
        if (wb_stb_o) begin
          if (wb_ack_i) begin
            cyc_d = 1'b0;
            stb_d = 1'b0;
            we_d  = 1'b0;
            if (state == S_WRITE) begin
              wcnt_d = wcnt + 8'd1;
              if (wcnt == LAST_W) begin
                state_d = S_READ;
              end else begin
                state_d   = S_FETCH;
                s_ready_d = 1'b1;
              end
            end else begin
              r_data_d  = wb_dat_i;
              r_valid_d = 1'b1;
              state_d   = S_PUSH;
            end
          end else if (tcnt == TMO) begin
            cyc_d   = 1'b0;
            stb_d   = 1'b0;
            we_d    = 1'b0;
            error_d = 1'b1;
            state_d = S_ERR;
          end else begin
            tcnt_d = tcnt + 8'd1;
          end
        end else if (state == S_READ) begin
          // READ is entered with cyc low so each read is preceded by an idle bus cycle.
          cyc_d  = 1'b1;
          stb_d  = 1'b1;
          tcnt_d = '0;
        end
      end
      S_PUSH: begin
        if (r_valid && r_ready) begin
          r_valid_d = 1'b0;
          rcnt_d    = rcnt + 8'd1;
          if (rcnt == LAST_R) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_READ;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE) && (state_d != S_ERR);
  end

endmodule
